// File: rtl/alu32_pkg.sv
// alu32_pkg
//   Shared definitions for the alu32 command controller: the alu32 opcode
//   map, the two-bit op_done status encodings reported by alu32, and the
//   controller FSM state encoding.
//   No ports; imported with "import alu32_pkg::*;".

package alu32_pkg;

  // alu32 opcodes
  localparam logic [3:0] OP_NOT_A = 4'h0;
  localparam logic [3:0] OP_NOT_B = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_XNOR  = 4'h5;
  localparam logic [3:0] OP_LT    = 4'h6;
  localparam logic [3:0] OP_GT    = 4'h7;
  localparam logic [3:0] OP_LSL   = 4'h8;
  localparam logic [3:0] OP_LSR   = 4'h9;
  localparam logic [3:0] OP_ASR   = 4'hA;
  localparam logic [3:0] OP_ADD   = 4'hB;
  localparam logic [3:0] OP_SUB   = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;

  // Highest opcode alu32 implements; anything above is rejected.
  localparam logic [3:0] OP_LAST  = OP_MUL;

  // alu32 op_done status. 2'b01 is reserved and counts as busy.
  localparam logic [1:0] DONE_IDLE = 2'b00;
  localparam logic [1:0] DONE_BUSY = 2'b10;
  localparam logic [1:0] DONE_DONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  function automatic logic opcode_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu32_ctrl.sv
// alu32_ctrl
//   Command controller in front of an alu32 core. Accepts one command at a
//   time, drives operands/opcode to alu32 with a single start strobe, polls
//   alu32 status with a bounded wait, returns the captured results through a
//   valid/ready response port and finally clears alu32 with one clear strobe.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | cmd_ready=1, waiting for a command
//   ISSUE | alu_op_start=1 for one cycle
//   WAIT  | sample alu32 status/results each cycle, count toward TIMEOUT
//   RESP  | rsp_valid=1, response held until rsp_ready
//   CLEAR | alu_op_clear=1 for one cycle, sampled copies and counter zeroed
//
// Parameters
//   TIMEOUT             maximum number of WAIT cycles before an abort (>=1)
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_opcode,cmd_a/b  command opcode and operands
//   alu_a/b, alu_opcode operands/opcode to alu32, held for the operation
//   alu_op_start/clear  start and clear strobes to alu32
//   alu_op_done         alu32 status (00 idle, 10/01 busy, 11 done)
//   alu_result1/2       alu32 results (result2 = upper MUL word)
//   alu_*_before        alu32 status/results registered during WAIT
//   rsp_valid/ready     response handshake
//   rsp_result1/2       captured results (zero on error)
//   rsp_error           illegal opcode or timeout

module alu32_ctrl
  import alu32_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_op_start,
  output logic        alu_op_clear,
  output logic [1:0]  alu_op_done_before,
  output logic [31:0] alu_result1_before,
  output logic [31:0] alu_result2_before,
  input  logic [31:0] alu_result1,
  input  logic [31:0] alu_result2,
  input  logic [1:0]  alu_op_done,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result1,
  output logic [31:0] rsp_result2,
  output logic        rsp_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value during the last permitted WAIT cycle; the increment on that
  // cycle brings the counter to TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             live;
  logic [CNT_W-1:0] wait_cnt;

  logic accept;
  logic done_hit;
  logic timeout_hit;

  assign accept      = cmd_valid && cmd_ready;
  assign done_hit    = (alu_op_done == DONE_DONE);
  assign timeout_hit = (wait_cnt == CNT_LAST);

  // State register. live holds cmd_ready low while reset is high and lets it
  // rise on the first clock edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = opcode_legal(cmd_opcode) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_hit || timeout_hit) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; start and clear come from distinct states so they are
  // mutually exclusive by construction.
  always_comb begin
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_op_start = 1'b0;
    alu_op_clear = 1'b0;
    case (state)
      ST_IDLE:  cmd_ready    = live;
      ST_ISSUE: alu_op_start = 1'b1;
      ST_RESP:  rsp_valid    = 1'b1;
      ST_CLEAR: alu_op_clear = 1'b1;
      default:  ;
    endcase
  end

  // Command latch, alu32 sampling, timeout counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a              <= '0;
      alu_b              <= '0;
      alu_opcode         <= '0;
      alu_op_done_before <= '0;
      alu_result1_before <= '0;
      alu_result2_before <= '0;
      wait_cnt           <= '0;
      rsp_result1        <= '0;
      rsp_result2        <= '0;
      rsp_error          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_opcode <= cmd_opcode;
            if (!opcode_legal(cmd_opcode)) begin
              rsp_result1 <= '0;
              rsp_result2 <= '0;
              rsp_error   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          alu_op_done_before <= alu_op_done;
          alu_result1_before <= alu_result1;
          alu_result2_before <= alu_result2;
          wait_cnt           <= wait_cnt + 1'b1;
          // Done takes priority over a timeout landing in the same cycle.
          if (done_hit) begin
            rsp_result1 <= alu_result1;
            rsp_result2 <= alu_result2;
            rsp_error   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result1 <= '0;
            rsp_result2 <= '0;
            rsp_error   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          alu_op_done_before <= '0;
          alu_result1_before <= '0;
          alu_result2_before <= '0;
          wait_cnt           <= '0;
          rsp_result1        <= '0;
          rsp_result2        <= '0;
          rsp_error          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_ctrl.sv
// tb_alu32_ctrl
//   Scoreboard bench for alu32_ctrl with a behavioural alu32 stub whose
//   busy latency is chosen per command.

module tb_alu32_ctrl;
  import alu32_pkg::*;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_op_start, alu_op_clear;
  logic [1:0]  alu_op_done_before;
  logic [31:0] alu_result1_before, alu_result2_before;
  logic [31:0] alu_result1, alu_result2;
  logic [1:0]  alu_op_done;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result1, rsp_result2;
  logic        rsp_error;

  always #5 clk = ~clk;

  alu32_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_op_start(alu_op_start), .alu_op_clear(alu_op_clear),
    .alu_op_done_before(alu_op_done_before),
    .alu_result1_before(alu_result1_before), .alu_result2_before(alu_result2_before),
    .alu_result1(alu_result1), .alu_result2(alu_result2), .alu_op_done(alu_op_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result1(rsp_result1), .rsp_result2(rsp_result2), .rsp_error(rsp_error)
  );

  int checks = 0;
  int errors = 0;

  // Reference ALU: returns {result2, result1}
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      4'h0: r[31:0] = ~a;
      4'h1: r[31:0] = ~b;
      4'h2: r[31:0] = a & b;
      4'h3: r[31:0] = a | b;
      4'h4: r[31:0] = a ^ b;
      4'h5: r[31:0] = ~(a ^ b);
      4'h6: r[31:0] = (a < b) ? 32'd1 : 32'd0;
      4'h7: r[31:0] = (a > b) ? 32'd1 : 32'd0;
      4'h8: r[31:0] = a << b[4:0];
      4'h9: r[31:0] = a >> b[4:0];
      4'hA: r[31:0] = 32'($signed(a) >>> b[4:0]);
      4'hB: r[31:0] = a + b;
      4'hC: r[31:0] = a - b;
      4'hD: r = 64'(a) * 64'(b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // alu32 stub: busy for stub_lat cycles after start, then done until clear.
  int   stub_lat;
  logic stub_rsvd;
  int   rem;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_done <= 2'b00; alu_result1 <= '0; alu_result2 <= '0; rem <= 0;
    end else if (alu_op_clear) begin
      alu_op_done <= 2'b00; alu_result1 <= '0; alu_result2 <= '0; rem <= 0;
    end else if (alu_op_start) begin
      if (stub_lat == 0) begin
        alu_op_done <= 2'b11;
        {alu_result2, alu_result1} <= alu_fn(alu_opcode, alu_a, alu_b);
      end else begin
        alu_op_done <= stub_rsvd ? 2'b01 : 2'b10;
        rem <= stub_lat;
        alu_result1 <= $urandom; alu_result2 <= $urandom;
      end
    end else if (alu_op_done == 2'b10 || alu_op_done == 2'b01) begin
      if (rem == 1) begin
        alu_op_done <= 2'b11;
        {alu_result2, alu_result1} <= alu_fn(alu_opcode, alu_a, alu_b);
      end else begin
        rem <= rem - 1;
        alu_result1 <= $urandom; alu_result2 <= $urandom;
      end
    end
  end

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        err;
    int          starts;
  } exp_t;
  exp_t sb_q[$];

  // Monitor state
  logic [1:0]  prev_done;
  logic [31:0] prev_r1, prev_r2;
  logic        prev_valid, prev_clear;
  int          start_cnt;
  logic        overlap_bad, before_bad, hold_bad;
  logic [31:0] hold_r1, hold_r2;
  logic        hold_err;
  logic        saw_busy_b, saw_done_b, last_saw_busy, last_saw_done;
  logic        clear_due;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_done = 0; prev_r1 = 0; prev_r2 = 0; prev_valid = 0; prev_clear = 0;
      start_cnt = 0; overlap_bad = 0; before_bad = 0; hold_bad = 0;
      saw_busy_b = 0; saw_done_b = 0; clear_due = 0;
    end else begin
      if (clear_due) begin
        checks++;
        if (!alu_op_clear || rsp_valid)
          $display("FAIL clear_after_hs: clear=%0b rsp_valid=%0b, want clear=1 rsp_valid=0", alu_op_clear, rsp_valid);
        if (!alu_op_clear || rsp_valid) errors++;
        clear_due = 0;
      end
      if (alu_op_start) start_cnt++;
      if (alu_op_start && alu_op_clear) overlap_bad = 1;
      if (alu_op_start && alu_op_done_before != 2'b00) before_bad = 1;
      if (!prev_valid && !prev_clear && prev_done != 2'b00) begin
        if (alu_op_done_before != prev_done || alu_result1_before != prev_r1 ||
            alu_result2_before != prev_r2) before_bad = 1;
        if (alu_op_done_before == 2'b10) saw_busy_b = 1;
        if (alu_op_done_before == 2'b11) saw_done_b = 1;
      end
      if (rsp_valid) begin
        if (cmd_ready) hold_bad = 1;
        if (prev_valid && (rsp_result1 != hold_r1 || rsp_result2 != hold_r2 || rsp_error != hold_err))
          hold_bad = 1;
        hold_r1 = rsp_result1; hold_r2 = rsp_result2; hold_err = rsp_error;
        if (rsp_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got r1=%h r2=%h err=%0b with nothing outstanding",
                     rsp_result1, rsp_result2, rsp_error);
          end else begin
            e = sb_q.pop_front();
            checks++;
            if (rsp_result1 !== e.r1) begin errors++; $display("FAIL rsp_result1: got %h want %h", rsp_result1, e.r1); end
            checks++;
            if (rsp_result2 !== e.r2) begin errors++; $display("FAIL rsp_result2: got %h want %h", rsp_result2, e.r2); end
            checks++;
            if (rsp_error !== e.err) begin errors++; $display("FAIL rsp_error: got %0b want %0b", rsp_error, e.err); end
            checks++;
            if (start_cnt != e.starts) begin errors++; $display("FAIL start_pulses: got %0d want %0d", start_cnt, e.starts); end
            checks++;
            if (overlap_bad || before_bad || hold_bad) begin
              errors++;
              $display("FAIL protocol: overlap=%0b before_track=%0b rsp_hold=%0b, want all 0",
                       overlap_bad, before_bad, hold_bad);
            end
          end
          last_saw_busy = saw_busy_b; last_saw_done = saw_done_b;
          start_cnt = 0; overlap_bad = 0; before_bad = 0; hold_bad = 0;
          saw_busy_b = 0; saw_done_b = 0; clear_due = 1;
        end
      end
      prev_valid = rsp_valid; prev_clear = alu_op_clear; prev_done = alu_op_done;
      prev_r1 = alu_result1; prev_r2 = alu_result2;
    end
  end

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready, alu_a, alu_b, alu_opcode, alu_op_start, alu_op_clear,
             alu_op_done_before, alu_result1_before, alu_result2_before,
             rsp_valid, rsp_result1, rsp_result2, rsp_error};
  endfunction

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    ok = cmd_ready;
    if (!ok) begin checks++; errors++; $display("FAIL cmd_ready_wait: got 0 want 1 within 200 cycles"); end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic rsvd, input int rdly, output int lag);
    exp_t e;
    logic [63:0] r;
    logic ok;
    int n;
    lag = 0;
    stub_lat = lat; stub_rsvd = rsvd;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    r = alu_fn(op, a, b);
    e.err = (op > 4'hD) || (lat >= TMO);
    e.r1 = e.err ? 32'd0 : r[31:0];
    e.r2 = e.err ? 32'd0 : r[63:32];
    e.starts = (op > 4'hD) ? 0 : 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_opcode = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom;
    n = 1;
    while (!rsp_valid && n < TMO + 20) begin @(posedge clk); #1; n++; end
    lag = n;
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_valid_wait: got 0 want 1 within %0d cycles", TMO + 20);
      sb_q.delete();
      return;
    end
    for (int i = 0; i < rdly; i++) begin @(posedge clk); #1; end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    int lag;
    logic ok;
    reset = 1; cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
    stub_lat = 1; stub_rsvd = 0;
    last_saw_busy = 0; last_saw_done = 0;
    repeat (3) @(posedge clk);
    #2;
    check1("reset_outputs_zero", 64'(any_out()), 64'd0);
    @(negedge clk); #1 reset = 0;
    #1 check1("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    check1("cmd_ready_first_edge", 64'(cmd_ready), 64'd1);

    // ADD
    run_cmd(4'hB, 32'h0000_1000, 32'h0010_1000, 3, 0, 0, lag);
    // MUL with 32 busy cycles
    run_cmd(4'hD, 32'h0001_0000, 32'h0001_0000, 32, 0, 1, lag);
    check1("mul_done_before_10_then_11", 64'({last_saw_busy, last_saw_done}), 64'b11);
    // illegal opcode
    run_cmd(4'hE, $urandom, $urandom, 2, 0, 0, lag);
    checks++;
    if (lag > 2) begin errors++; $display("FAIL illegal_rsp_latency: got %0d cycles want <=2", lag); end
    run_cmd(4'hF, $urandom, $urandom, 2, 0, 2, lag);
    // stuck busy -> timeout
    run_cmd(4'hC, 32'h5, 32'h3, 1000, 0, 1, lag);
    // done on the timeout cycle wins; one later times out
    run_cmd(4'h4, $urandom, $urandom, TMO - 1, 0, 0, lag);
    run_cmd(4'h4, $urandom, $urandom, TMO, 0, 0, lag);
    // long backpressure
    run_cmd(4'hB, 32'hFFFF_FFFF, 32'h2, 4, 0, 10, lag);
    // reserved busy code
    run_cmd(4'hA, 32'h8000_0010, 32'h4, 5, 1, 0, lag);

    // reset during WAIT of a MUL
    stub_lat = 32; stub_rsvd = 0;
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1; cmd_opcode = 4'hD; cmd_a = 32'h1234; cmd_b = 32'h5678;
      @(posedge clk); #1 cmd_valid = 0;
      repeat (10) @(posedge clk);
      #2 reset = 1;
      #1 check1("midop_reset_outputs_zero", 64'(any_out()), 64'd0);
      @(negedge clk); @(negedge clk); #1 reset = 0;
      ok = 0;
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (rsp_valid) ok = 1; end
      check1("midop_reset_no_rsp", 64'(ok), 64'd0);
      run_cmd(4'hD, 32'hDEAD_BEEF, 32'h0000_0100, 6, 0, 0, lag);
    end

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      int lat;
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO - 2, TMO + 1)) : int'($urandom_range(0, 6));
      run_cmd(4'($urandom_range(0, 15)), $urandom, $urandom, lat, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), lag);
    end

    repeat (4) @(posedge clk); #1;
    check1("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
